// File: rtl/sevenseg_scan_if.sv
// sevenseg_scan_if: signal bundle between the time-digit counters and the display scanner.
//   master : drives enable, the four BCD digits, colon request and leading-zero blank enable;
//            receives segment, digit-enable and colon drives.
//   slave  : the scanner side (inputs and outputs mirrored).
// Signals:
//   en_i     display enable
//   min_u_i  minutes units (BCD)      min_t_i  minutes tens (BCD)
//   hr_u_i   hours units (BCD)        hr_t_i   hours tens (BCD)
//   colon_i  colon request            lzb_i    leading-zero blank for hours tens
//   seg_o    segments {g,f,e,d,c,b,a} dig_o    digit enables (bit0 = min_u .. bit3 = hr_t)
//   colon_o  colon drive
interface sevenseg_scan_if;
   logic       en_i;
   logic [3:0] min_u_i;
   logic [3:0] min_t_i;
   logic [3:0] hr_u_i;
   logic [3:0] hr_t_i;
   logic       colon_i;
   logic       lzb_i;
   logic [6:0] seg_o;
   logic [3:0] dig_o;
   logic       colon_o;

   modport master (
      output en_i, min_u_i, min_t_i, hr_u_i, hr_t_i, colon_i, lzb_i,
      input  seg_o, dig_o, colon_o
   );

   modport slave (
      input  en_i, min_u_i, min_t_i, hr_u_i, hr_t_i, colon_i, lzb_i,
      output seg_o, dig_o, colon_o
   );
endinterface

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: decodes four BCD time digits to 7-segment patterns and time-multiplexes them
// onto one shared segment bus, with a dark interval at the start of every digit slot.
// Ports:
//   clk_i   scan clock (only clock)
//   rstn_i  asynchronous active-low reset
//   bus     sevenseg_scan_if.slave: en_i, digits, colon_i, lzb_i in; seg_o, dig_o, colon_o out
// Parameters:
//   SCAN_DIV      cycles per digit slot (blank + show), must be >= BLANK_CYCLES + 1
//   BLANK_CYCLES  dark cycles at the start of each slot, must be >= 1
//   COMMON_ANODE  1 inverts seg_o, dig_o and colon_o (active-low pads)
// All outputs come straight from flops; polarity is folded in before the flop.
module sevenseg_scan #(
   parameter int unsigned SCAN_DIV     = 64,
   parameter int unsigned BLANK_CYCLES = 8,
   parameter bit          COMMON_ANODE = 1'b0
) (
   input  logic           clk_i,
   input  logic           rstn_i,
   sevenseg_scan_if.slave bus
);

   localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] LastBlank = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] LastSlot  = CW'(SCAN_DIV - 1);
   localparam logic [6:0]    SegOff    = {7{COMMON_ANODE}};
   localparam logic [3:0]    DigOff    = {4{COMMON_ANODE}};
   localparam logic          ColOff    = COMMON_ANODE;

   typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

   state_e        r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_slot;
   logic [3:0]    r_snap;
   logic          r_lzb;
   logic [6:0]    r_seg;
   logic [3:0]    r_dig;
   logic          r_colon;

   logic [3:0]    w_sel;
   logic [3:0]    w_snap;
   logic          w_lzb;
   logic          w_dark;
   logic [6:0]    w_seg_dec;
   logic [3:0]    w_dig_hot;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b0000000;  // non-BCD codes show nothing but keep the digit enabled
      endcase
      return s;
   endfunction

   always_comb begin
      w_sel = bus.min_u_i;
      unique case (r_slot)
         2'd0: w_sel = bus.min_u_i;
         2'd1: w_sel = bus.min_t_i;
         2'd2: w_sel = bus.hr_u_i;
         2'd3: w_sel = bus.hr_t_i;
      endcase
   end

   // With a single blank cycle the snapshot and the show load fall on the same edge, so the
   // decode must see the value being captured rather than the stale register.
   always_comb begin
      w_snap    = (r_cnt == '0) ? w_sel : r_snap;
      w_lzb     = (r_cnt == '0) ? bus.lzb_i : r_lzb;
      w_dark    = (r_slot == 2'd3) && w_lzb && (w_snap == 4'd0);
      w_seg_dec = seg_decode(w_snap);
      w_dig_hot = 4'b0001 << r_slot;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_slot  <= '0;
         r_snap  <= '0;
         r_lzb   <= 1'b0;
         r_seg   <= SegOff;
         r_dig   <= DigOff;
         r_colon <= ColOff;
      end else if (!bus.en_i) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_slot  <= '0;
         r_seg   <= SegOff;
         r_dig   <= DigOff;
         r_colon <= ColOff;
      end else begin
         r_colon <= bus.colon_i ^ ColOff;
         unique case (r_state)
            StIdle: begin
               r_state <= StBlank;
               r_cnt   <= '0;
               r_slot  <= '0;
            end
            StBlank: begin
               if (r_cnt == '0) begin
                  r_snap <= w_sel;
                  r_lzb  <= bus.lzb_i;
               end
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LastBlank) begin
                  r_state <= StShow;
                  r_dig   <= (w_dark ? 4'b0000 : w_dig_hot) ^ DigOff;
                  r_seg   <= (w_dark ? 7'b0000000 : w_seg_dec) ^ SegOff;
               end
            end
            StShow: begin
               if (r_cnt == LastSlot) begin
                  r_state <= StBlank;
                  r_cnt   <= '0;
                  r_slot  <= r_slot + 2'd1;
                  r_seg   <= SegOff;
                  r_dig   <= DigOff;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= StIdle;
               r_cnt   <= '0;
               r_slot  <= '0;
               r_seg   <= SegOff;
               r_dig   <= DigOff;
            end
         endcase
      end
   end

   assign bus.seg_o   = r_seg;
   assign bus.dig_o   = r_dig;
   assign bus.colon_o = r_colon;

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
- Downstream display stage for the watch's time-digit counters.
- Takes four fully encoded BCD digits (minutes units, minutes tens, hours units, hours tens) and a colon request.
- Decodes each digit to 7-segment patterns and time-multiplexes the four digits onto one shared segment bus.
- Inserts a blanking interval between digits to suppress ghosting.
- Sits between the digit counters and the chip pads.

Parameters:
- SCAN_DIV, 64: clock cycles per digit slot (blank plus show). Legal only when SCAN_DIV >= BLANK_CYCLES+1.
- BLANK_CYCLES, 8: cycles at the start of each slot with all digits off. Must be >= 1.
- COMMON_ANODE, 0:
  - 0: seg_o and dig_o are active-high.
  - 1: seg_o, dig_o and colon_o are all inverted (active-low).

Ports:
- clk_i  input  1  scan clock. Only clock in the block.
- rstn_i  input  1  reset, asynchronous assert, active-low.
- en_i  input  1  display enable, synchronous.
- min_u_i  input  4  minutes units, BCD.
- min_t_i  input  4  minutes tens, BCD.
- hr_u_i  input  4  hours units, BCD.
- hr_t_i  input  4  hours tens, BCD.
- colon_i  input  1  colon request (e.g. seconds blink).
- lzb_i  input  1  leading-zero blank enable for hours tens.
- seg_o  output  7  segments {g,f,e,d,c,b,a}, registered.
- dig_o  output  4  digit enables; bit0 = min_u, bit1 = min_t, bit2 = hr_u, bit3 = hr_t. Registered.
- colon_o  output  1  colon drive, registered.

Behaviour:
- Polarity: "active" and "off" below are logical levels. COMMON_ANODE inverts every output at the register input, never combinationally after the flop.

Reset (rstn_i low, asynchronous):
- Slot index = 0, cycle counter = 0, state = IDLE.
- Digit snapshot register = 0.
- seg_o, dig_o and colon_o all off. All-zero when COMMON_ANODE=0; all-one when COMMON_ANODE=1.

State machine: IDLE, BLANK, SHOW.
- IDLE:
  - Outputs off.
  - Counter = 0, slot = 0.
  - Go to BLANK on the first edge with en_i=1.
- BLANK:
  - On entry (counter = 0), snapshot the digit selected by the slot index into a 4-bit register. The inputs may change at any time; the displayed value only changes at slot boundaries.
  - dig_o and seg_o are off.
  - Counter increments each cycle.
  - When counter reaches BLANK_CYCLES-1, go to SHOW. On that same edge, dig_o[slot] and seg_o load their active values.
- SHOW:
  - dig_o holds one-hot (or one-cold) on the current slot.
  - seg_o holds the decoded snapshot.
  - When counter reaches SCAN_DIV-1: counter wraps to 0, slot increments modulo 4 (3 -> 0), go to BLANK, and dig_o and seg_o go off on that edge.
- Resulting timing:
  - Each digit is lit for exactly SCAN_DIV-BLANK_CYCLES cycles.
  - Each digit is preceded by BLANK_CYCLES dark cycles.
  - A full frame takes 4*SCAN_DIV cycles.
  - Never more than one dig_o bit is active.

Enable:
- en_i=0 in any state goes to IDLE on the next edge.
- All outputs go off on that same edge.
- Re-enable always restarts at slot 0, counter 0.

Decode:
- Standard patterns for 0-9. 0 = 0111111; 1 = 0000110; 7 = 0000111; 8 = 1111111.
- Codes 10-15: all segments off, and the digit enable is still asserted.

Leading-zero blank:
- Applies when lzb_i=1 and the hours-tens snapshot = 0.
- Slot 3 stays fully dark: dig_o[3] and seg_o both off for the whole slot.
- Slot timing is unchanged.
- lzb_i is sampled together with the snapshot.

Colon:
- colon_o = colon_i registered (1-cycle latency) while en_i=1 and not in reset.
- colon_o is off in IDLE.
- colon_o is not multiplexed.

Widths:
- Cycle counter is $clog2(SCAN_DIV) bits.
- Slot index is 2 bits.
- No other arithmetic.

Test Plan:
- Reset and start:
  - Setup: SCAN_DIV=8, BLANK_CYCLES=2, COMMON_ANODE=0; digits 1,2,3,0 (hr_t..min_u = 1,2,3,0). Hold reset, release with en_i=1.
  - Required during reset: seg_o=0, dig_o=0, colon_o=0.
  - Required after release: dig_o=0001 and seg_o=0111111 exactly 3 edges after release (1 edge IDLE->BLANK, then 2 blank edges), held for 6 cycles; then 2 dark cycles; then dig_o=0010 with seg_o=1001111 ("3"); frame repeats every 32 cycles.
- Input change mid-slot:
  - Stimulus: change min_u_i 0 -> 5 while dig_o=0001.
  - Required: seg_o stays 0111111 until the slot ends; the next frame's slot 0 shows 1101101.
- Leading zero:
  - Stimulus: hr_t_i=0, lzb_i=1.
  - Required: dig_o never equals 1000; the slot-3 window is 8 dark cycles.
  - Then set lzb_i=0: dig_o=1000 with seg_o=0111111.
- Invalid code and polarity:
  - Stimulus: COMMON_ANODE=1, min_t_i=4'hC.
  - Required: during slot 1, dig_o=1101 and seg_o=1111111.
  - Required: during blank, dig_o=1111.
- Enable and async reset mid-operation:
  - Stimulus: drop en_i during SHOW of slot 2.
  - Required: all outputs off on the next edge; re-enabling restarts at slot 0 after BLANK_CYCLES.
  - Stimulus: pulse rstn_i low for under one cycle mid-SHOW.
  - Required: outputs go off immediately, asynchronously, without waiting for an edge.
- Colon and exclusivity:
  - Stimulus: toggle colon_i every 16 cycles.
  - Required: colon_o follows colon_i with 1-cycle lag while en_i=1.
  - Required (assertion, all runs): $countones(dig_o active) <= 1 on every cycle.
